// File: rtl/top_selftest_pkg.sv
// top_selftest_pkg: shared FSM states, LFSR constants and helpers for the self-test block
package top_selftest_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    localparam int LFSR_W = 8;
    localparam logic [LFSR_W-1:0] TAP_MASK = 8'hB8;
    localparam logic [LFSR_W-1:0] SEED_FALLBACK = 8'h01;
    function automatic logic [LFSR_W-1:0] seed_fix(input logic [LFSR_W-1:0] s);
        return s == '0 ? SEED_FALLBACK : s;
    endfunction
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
        return {v[LFSR_W-2:0], ^(v & TAP_MASK)};
    endfunction
endpackage

// File: rtl/lfsr8.sv
// lfsr8: 8-bit Fibonacci LFSR with seed load (zero seed replaced) and step enable
module lfsr8 import top_selftest_pkg::*; (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              step,
    output logic [LFSR_W-1:0] value
);
    always_ff @(posedge clk or posedge rst)
        if (rst)
            value <= SEED_FALLBACK;
        else if (load)
            value <= seed_fix(seed);
        else if (step)
            value <= lfsr_next(value);
endmodule

// File: rtl/top_selftest.sv
// top_selftest: LFSR-driven self-test of an AND / MUX / DFF device with error accounting
module top_selftest import top_selftest_pkg::*; #(
    parameter int NVEC_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        seed,
    input  logic [NVEC_W-1:0] num_vec,
    output logic              a,
    output logic              b,
    output logic              sel,
    input  logic              y_comb,
    input  logic              y_mux,
    input  logic              q_dff,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [NVEC_W-1:0] err_cnt,
    output logic [NVEC_W-1:0] first_err_idx
);
    state_t state, state_n;
    logic [LFSR_W-1:0] lfsr_val;
    logic [NVEC_W-1:0] idx, num_vec_r;
    logic [2:0] stim_src;
    logic a_prev, accept, last, fail_c, fail_q, fail;

    assign accept = state == IDLE && start;
    // num_vec=0 wraps to all-ones here, giving the full 2**NVEC_W vectors
    assign last = state == RUN && idx == num_vec_r - NVEC_W'(1);
    assign fail_c = state == RUN && (y_comb != (a & b) || y_mux != (sel ? b : a));
    assign fail_q = ((state == RUN && idx != '0) || state == DRAIN) && q_dff != a_prev;
    assign fail = fail_c | fail_q;
    // low three bits of the value the LFSR will hold after this edge
    assign stim_src = accept ? (seed == '0 ? SEED_FALLBACK[2:0] : seed[2:0])
                             : {lfsr_val[1:0], ^(lfsr_val & TAP_MASK)};

    lfsr8 u_lfsr (
        .clk(clk),
        .rst(rst),
        .load(accept),
        .seed(seed),
        .step(state == RUN),
        .value(lfsr_val)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst)
            state <= IDLE;
        else
            state <= state_n;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start ? RUN : IDLE;
            RUN:     state_n = last ? DRAIN : RUN;
            DRAIN:   state_n = DONE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        busy = state == RUN || state == DRAIN;
        done = state == DONE;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            {sel, b, a} <= 3'b000;
            a_prev <= 1'b0;
            idx <= '0;
            num_vec_r <= '0;
            err_cnt <= '0;
            first_err_idx <= '0;
            pass <= 1'b0;
        end else begin
            {sel, b, a} <= (accept || (state == RUN && !last)) ? stim_src : 3'b000;
            a_prev <= a;
            if (accept) begin
                idx <= '0;
                num_vec_r <= num_vec;
                err_cnt <= '0;
                first_err_idx <= '0;
                pass <= 1'b0;
            end else begin
                if (state == RUN && !last)
                    idx <= idx + NVEC_W'(1);
                if (fail && err_cnt != '1)
                    err_cnt <= err_cnt + NVEC_W'(1);
                // a q_dff miss in RUN belongs to the previous vector
                if (fail && err_cnt == '0)
                    first_err_idx <= (fail_q && state == RUN) ? idx - NVEC_W'(1) : idx;
                if (state == DRAIN)
                    pass <= !fail && err_cnt == '0;
            end
        end
endmodule

// File: tb/tb_top_selftest.sv
// tb_top_selftest: randomized self-checking bench with a fault-injecting device model
module tb_top_selftest;
    logic clk = 1'b0;
    logic rst, start;
    logic [7:0] seed, num_vec;
    logic a, b, sel, y_comb, y_mux, q_dff, busy, done, pass;
    logic [7:0] err_cnt, first_err_idx;
    logic q_reg, inj_c, inj_m, inj_q;
    int checks = 0;
    int errors = 0;
    bit va[256], vb[256], vs[256], cf[256], cm[256], qf[256];

    always #5 clk = ~clk;

    always @(posedge clk) q_reg <= a;
    assign y_comb = (a & b) ^ inj_c;
    assign y_mux = (sel ? b : a) ^ inj_m;
    assign q_dff = q_reg ^ inj_q;

    top_selftest #(.NVEC_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .seed(seed), .num_vec(num_vec),
        .a(a), .b(b), .sel(sel), .y_comb(y_comb), .y_mux(y_mux), .q_dff(q_dff),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .first_err_idx(first_err_idx)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // mode: 0 no faults, 1 fault on every vector, 2 random faults
    task automatic run(input logic [7:0] s, input logic [7:0] nv, input bit hold,
                       input int cmode, input int qmode);
        int n, exp_cnt, exp_first;
        bit seen;
        logic [7:0] v;
        n = nv == 0 ? 256 : int'(nv);
        v = s == 0 ? 8'h01 : s;
        exp_cnt = 0;
        exp_first = 0;
        seen = 0;
        for (int k = 0; k < n; k++) begin
            va[k] = v[0];
            vb[k] = v[1];
            vs[k] = v[2];
            v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
            cf[k] = cmode == 1 ? 1'b1 : cmode == 2 ? ($urandom_range(3) == 0) : 1'b0;
            qf[k] = qmode == 1 ? 1'b1 : qmode == 2 ? ($urandom_range(3) == 0) : 1'b0;
            cm[k] = 1'($urandom_range(1));
        end
        for (int e = 0; e <= n; e++) begin
            bit fc, fq;
            fc = e < n && cf[e];
            fq = e >= 1 && qf[e-1];
            if (fc || fq) begin
                if (!seen) exp_first = fq ? e - 1 : e;
                seen = 1;
                exp_cnt++;
            end
        end
        @(negedge clk);
        seed = s;
        num_vec = nv;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        seed = 8'($urandom);
        num_vec = 8'($urandom_range(1, 3));
        for (int j = 0; j <= n; j++) begin
            inj_c = j < n && cf[j] && !cm[j];
            inj_m = j < n && cf[j] && cm[j];
            inj_q = j >= 1 && qf[j-1];
            chk("stim", {29'b0, a, b, sel}, j < n ? {29'b0, va[j], vb[j], vs[j]} : 32'b0);
            chk("busy", busy, 1);
            chk("done_early", done, 0);
            @(posedge clk);
            #1;
        end
        inj_c = 0;
        inj_m = 0;
        inj_q = 0;
        chk("done", done, 1);
        chk("busy_done", busy, 0);
        chk("err_cnt", err_cnt, exp_cnt > 255 ? 255 : exp_cnt);
        chk("first_err_idx", first_err_idx, exp_first);
        chk("pass", pass, exp_cnt == 0);
        chk("stim_done", {a, b, sel}, 0);
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("done_once", done, 0);
        chk("busy_idle", busy, 0);
        chk("pass_hold", pass, exp_cnt == 0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        seed = 8'h00;
        num_vec = 8'h00;
        inj_c = 0;
        inj_m = 0;
        inj_q = 0;
        #12;
        chk("reset_outs", {a, b, sel, busy, done, pass, err_cnt, first_err_idx}, 0);
        @(negedge clk);
        rst = 1'b0;
        run(8'h01, 8'd8, 0, 0, 0);
        run(8'h01, 8'd8, 0, 1, 0);
        run(8'h5A, 8'd8, 0, 0, 1);
        run(8'h01, 8'd0, 0, 1, 0);
        run(8'h01, 8'd8, 0, 0, 0);
        // reset mid-run at idx=3
        @(negedge clk);
        seed = 8'h01;
        num_vec = 8'd8;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("busy_mid", busy, 1);
        rst = 1'b1;
        #1;
        chk("rst_abort", {a, b, sel, busy, done, pass, err_cnt, first_err_idx}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            chk("no_done_after_rst", {busy, done}, 0);
        end
        run(8'h00, 8'd8, 0, 0, 0);
        run(8'h33, 8'd5, 1, 0, 0);
        run(8'hC7, 8'd6, 1, 2, 2);
        for (int i = 0; i < 20; i++)
            run(8'($urandom), 8'($urandom_range(1, 20)), 1'($urandom_range(1)),
                int'($urandom_range(2)), int'($urandom_range(2)));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/top_selftest.md
TOP_SELFTEST -- requirements
Module: top_selftest

Interface
REQ-001 Parameter NVEC_W, default 8, width of vector count and error fields.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  run request, sampled in IDLE only.
REQ-005 seed  input  8  LFSR seed, captured on accepted start.
REQ-006 num_vec  input  NVEC_W  vectors per run, captured on accepted start; 0 means 2**NVEC_W.
REQ-007 a, b, sel  output  1 each  registered stimulus to the device under test.
REQ-008 y_comb, y_mux, q_dff  input  1 each  responses from the device under test.
REQ-009 busy  output  1  high in RUN and DRAIN.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 pass  output  1  high when the last run had zero errors; holds until the next accepted start.
REQ-012 err_cnt  output  NVEC_W  saturating mismatch count.
REQ-013 first_err_idx  output  NVEC_W  vector index of the first mismatch; 0 when err_cnt=0.

Function
REQ-014 The FSM SHALL use states IDLE, RUN, DRAIN, DONE: IDLE->RUN on start; RUN->DRAIN after the last vector is checked; DRAIN->DONE; DONE->IDLE unconditionally.
REQ-015 On accepted start the block SHALL load lfsr=seed (8'h00 replaced by 8'h01), set idx=0, clear err_cnt, first_err_idx and pass, and drive a=lfsr[0], b=lfsr[1], sel=lfsr[2] from the loaded value.
REQ-016 The LFSR SHALL be 8-bit Fibonacci, x^8+x^6+x^5+x^4+1: lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}, advancing once per RUN edge.
REQ-017 Expected responses SHALL be y_comb = a&b, y_mux = sel ? b : a, and q_dff = a of the previous vector, one clock late.
REQ-018 At each RUN edge the block SHALL check y_comb and y_mux for vector idx, and check q_dff against a of vector idx-1 when idx>=1.
REQ-019 The DRAIN edge SHALL check only q_dff against a of the last vector.
REQ-020 err_cnt SHALL increment by at most 1 per edge, and only when a check on that edge fails.
REQ-021 err_cnt SHALL saturate at 2**NVEC_W-1.
REQ-022 first_err_idx SHALL record the failing vector index on the first failing edge; when both checks fail on that edge it SHALL record idx-1.
REQ-023 For N vectors, done SHALL pulse in the cycle N+1 cycles after the edge that sampled start.
REQ-024 pass SHALL be valid from done onward.
REQ-025 a, b and sel SHALL be driven to 0 in IDLE, DRAIN and DONE.
REQ-026 start SHALL be ignored in RUN, DRAIN and DONE.
REQ-027 num_vec=0 SHALL run 256 vectors when NVEC_W=8.

Reset
REQ-028 rst SHALL asynchronously force state=IDLE, lfsr=8'h01, idx=0, and a=b=sel=busy=done=pass=0, err_cnt=0, first_err_idx=0.
REQ-029 Reset during RUN SHALL abort the run with no done pulse; the next start SHALL run normally.

Structure
REQ-030 Package top_selftest_pkg SHALL hold the state enum, LFSR_W=8, the tap mask, and SEED_FALLBACK=8'h01.
REQ-031 The LFSR SHALL be a sub-module lfsr8 with ports clk, rst, load, seed, step and value.
REQ-032 The expected-response pipeline and error accounting SHALL remain in top_selftest.

Verification
REQ-033 Correct DUT model, seed=8'h01, num_vec=8:
- first vectors (a,b,sel) = (1,0,0), (0,1,0), (0,0,1);
- done 9 cycles after start; pass=1, err_cnt=0.
REQ-034 y_comb inverted, seed=8'h01, num_vec=8: err_cnt=8, first_err_idx=0, pass=0.
REQ-035 q_dff inverted, num_vec=8: err_cnt=8 (7 RUN edges plus DRAIN), first_err_idx=0.
REQ-036 num_vec=0, y_comb inverted: done 257 cycles after start, err_cnt=255 (saturated).
REQ-037 rst pulsed at idx=3: all outputs 0 immediately, no done; a later start with seed=8'h00 reproduces the seed=8'h01 sequence.
REQ-038 start held high throughout a run: exactly one done per run; starts during busy change neither the run length nor the captured seed.
